// File: rtl/arima_sample_streamer.sv
// arima_sample_streamer: walks a sample BRAM once per start request and hands each sample to an ARIMA core over a valid/ready handshake
// Ports: clk, reset (sync, active-high); start (level run request);
//        bram_en/bram_addr/bram_dout (one-cycle-latency BRAM read port);
//        sample_valid/sample_data/sample_ready/time_step (downstream handshake);
//        busy (run in progress), done (run finished, waiting for start to drop)
module arima_sample_streamer #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int NUM_SAMPLES = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              sample_valid,
    output logic [DATA_W-1:0] sample_data,
    input  logic              sample_ready,
    output logic [31:0]       time_step,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, READ, LATCH, PRESENT, DONE} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_SAMPLES - 1);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d, addr_q, addr_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [31:0]       ts_q, ts_d;
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        data_d  = data_q;
        ts_d    = ts_q;
        case (state_q)
            IDLE: if (start) begin
                idx_d   = '0;
                state_d = READ;
            end
            READ: state_d = LATCH;
            LATCH: begin
                data_d  = bram_dout;
                ts_d    = 32'(idx_q);
                valid_d = 1'b1;
                state_d = PRESENT;
            end
            PRESENT: if (sample_ready) begin
                valid_d = 1'b0;
                if (idx_q == LAST) state_d = DONE;
                else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = READ;
                end
            end
            DONE: if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // The address is captured on entry to READ so it holds its last value everywhere else
        addr_d = (state_d == READ) ? idx_d : addr_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ts_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ts_q    <= ts_d;
        end
    end
    assign bram_en      = (state_q == READ);
    assign bram_addr    = addr_q;
    assign sample_valid = valid_q;
    assign sample_data  = data_q;
    assign time_step    = ts_q;
    assign busy         = (state_q != IDLE) && (state_q != DONE);
    assign done         = (state_q == DONE);
endmodule

// File: tb/tb_arima_sample_streamer.sv
// tb_arima_sample_streamer: directed bench for a four-sample streamer and a single-sample streamer
module tb_arima_sample_streamer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_a = 1'b0, ready_a = 1'b0, start_b = 1'b0, ready_b = 1'b0;
    logic        en_a, en_b, valid_a, valid_b, busy_a, busy_b, done_a, done_b;
    logic [9:0]  addr_a, addr_b;
    logic [31:0] dout_a = '0, dout_b = '0, data_a, data_b, ts_a, ts_b;
    int          errors = 0, checks = 0, en_cnt_b = 0, hs_cnt_b = 0;

    always #5 clk = ~clk;

    arima_sample_streamer #(.DATA_W(32), .ADDR_W(10), .NUM_SAMPLES(4)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .bram_en(en_a), .bram_addr(addr_a),
        .bram_dout(dout_a), .sample_valid(valid_a), .sample_data(data_a),
        .sample_ready(ready_a), .time_step(ts_a), .busy(busy_a), .done(done_a)
    );

    arima_sample_streamer #(.DATA_W(32), .ADDR_W(10), .NUM_SAMPLES(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .bram_en(en_b), .bram_addr(addr_b),
        .bram_dout(dout_b), .sample_valid(valid_b), .sample_data(data_b),
        .sample_ready(ready_b), .time_step(ts_b), .busy(busy_b), .done(done_b)
    );

    always @(posedge clk) begin
        if (en_a) dout_a <= 32'h100 + 32'(addr_a);
        if (en_b) dout_b <= 32'hABCD_0000 + 32'(addr_b);
    end

    always @(negedge clk) begin
        if (en_b) en_cnt_b <= en_cnt_b + 1;
        if (valid_b && ready_b) hs_cnt_b <= hs_cnt_b + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({en_a, addr_a, valid_a, data_a, ts_a, busy_a, done_a} !== '0) begin
                errors++;
                $display("FAIL reset_a[%0d]: got en=%b addr=%h v=%b d=%h ts=%h busy=%b done=%b expected all zero",
                         i, en_a, addr_a, valid_a, data_a, ts_a, busy_a, done_a);
            end
            checks++;
            if ({en_b, addr_b, valid_b, data_b, ts_b, busy_b, done_b} !== '0) begin
                errors++;
                $display("FAIL reset_b[%0d]: got en=%b addr=%h v=%b d=%h ts=%h busy=%b done=%b expected all zero",
                         i, en_b, addr_b, valid_b, data_b, ts_b, busy_b, done_b);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_nominal();
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({en_a, addr_a, valid_a, busy_a} !== {1'b1, 10'(i), 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL nom_read[%0d]: got en=%b addr=%0d v=%b busy=%b expected en=1 addr=%0d v=0 busy=1",
                         i, en_a, addr_a, valid_a, busy_a, i);
            end
            tick();
            checks++;
            if ({en_a, valid_a, busy_a} !== 3'b001) begin
                errors++;
                $display("FAIL nom_latch[%0d]: got en=%b v=%b busy=%b expected en=0 v=0 busy=1", i, en_a, valid_a, busy_a);
            end
            tick();
            checks++;
            if ({en_a, valid_a, data_a, ts_a} !== {1'b0, 1'b1, 32'h100 + 32'(i), 32'(i)}) begin
                errors++;
                $display("FAIL nom_present[%0d]: got en=%b v=%b d=%h ts=%0d expected en=0 v=1 d=%h ts=%0d",
                         i, en_a, valid_a, data_a, ts_a, 32'h100 + 32'(i), i);
            end
            tick();
        end
        checks++;
        if ({done_a, busy_a, valid_a, en_a} !== 4'b1000) begin
            errors++;
            $display("FAIL nom_done: got done=%b busy=%b v=%b en=%b expected done=1 busy=0 v=0 en=0", done_a, busy_a, valid_a, en_a);
        end
    endtask

    task automatic test_held_start();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({done_a, busy_a, en_a} !== 3'b100) begin
                errors++;
                $display("FAIL held_start[%0d]: got done=%b busy=%b en=%b expected done=1 busy=0 en=0", i, done_a, busy_a, en_a);
            end
        end
        start_a = 1'b0;
        tick();
        checks++;
        if ({done_a, busy_a, en_a} !== 3'b000) begin
            errors++;
            $display("FAIL held_release: got done=%b busy=%b en=%b expected all 0", done_a, busy_a, en_a);
        end
        tick();
        checks++;
        if ({done_a, busy_a, en_a} !== 3'b000) begin
            errors++;
            $display("FAIL idle_stay: got done=%b busy=%b en=%b expected all 0", done_a, busy_a, en_a);
        end
    endtask

    task automatic test_backpressure();
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        tick();
        tick();
        ready_a = 1'b0;
        tick();
        tick();
        checks++;
        if ({valid_a, data_a, ts_a} !== {1'b1, 32'h101, 32'd1}) begin
            errors++;
            $display("FAIL bp_first: got v=%b d=%h ts=%0d expected v=1 d=00000101 ts=1", valid_a, data_a, ts_a);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({valid_a, data_a, ts_a, en_a, busy_a} !== {1'b1, 32'h101, 32'd1, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL bp_stall[%0d]: got v=%b d=%h ts=%0d en=%b busy=%b expected v=1 d=00000101 ts=1 en=0 busy=1",
                         i, valid_a, data_a, ts_a, en_a, busy_a);
            end
        end
        ready_a = 1'b1;
        tick();
        checks++;
        if ({valid_a, en_a, addr_a} !== {1'b0, 1'b1, 10'd2}) begin
            errors++;
            $display("FAIL bp_release: got v=%b en=%b addr=%0d expected v=0 en=1 addr=2", valid_a, en_a, addr_a);
        end
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if ({done_a, ts_a, data_a} !== {1'b1, 32'd3, 32'h103}) begin
            errors++;
            $display("FAIL bp_done: got done=%b ts=%0d d=%h expected done=1 ts=3 d=00000103", done_a, ts_a, data_a);
        end
        tick();
    endtask

    task automatic test_midrun_reset();
        ready_a = 1'b1;
        start_a = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        ready_a = 1'b0;
        tick();
        checks++;
        if ({valid_a, ts_a, data_a} !== {1'b1, 32'd2, 32'h102}) begin
            errors++;
            $display("FAIL mr_present: got v=%b ts=%0d d=%h expected v=1 ts=2 d=00000102", valid_a, ts_a, data_a);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({en_a, addr_a, valid_a, data_a, ts_a, busy_a, done_a} !== '0) begin
            errors++;
            $display("FAIL mr_reset: got en=%b addr=%h v=%b d=%h ts=%h busy=%b done=%b expected all zero",
                     en_a, addr_a, valid_a, data_a, ts_a, busy_a, done_a);
        end
        reset = 1'b0;
        ready_a = 1'b1;
        tick();
        checks++;
        if ({en_a, addr_a, busy_a} !== {1'b1, 10'd0, 1'b1}) begin
            errors++;
            $display("FAIL mr_restart: got en=%b addr=%0d busy=%b expected en=1 addr=0 busy=1", en_a, addr_a, busy_a);
        end
        tick();
        tick();
        checks++;
        if ({valid_a, ts_a, data_a} !== {1'b1, 32'd0, 32'h100}) begin
            errors++;
            $display("FAIL mr_first: got v=%b ts=%0d d=%h expected v=1 ts=0 d=00000100", valid_a, ts_a, data_a);
        end
        start_a = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single();
        ready_b = 1'b1;
        start_b = 1'b1;
        tick();
        checks++;
        if ({en_b, addr_b, busy_b} !== {1'b1, 10'd0, 1'b1}) begin
            errors++;
            $display("FAIL single_read: got en=%b addr=%0d busy=%b expected en=1 addr=0 busy=1", en_b, addr_b, busy_b);
        end
        tick();
        tick();
        checks++;
        if ({valid_b, data_b, ts_b} !== {1'b1, 32'hABCD_0000, 32'd0}) begin
            errors++;
            $display("FAIL single_present: got v=%b d=%h ts=%0d expected v=1 d=abcd0000 ts=0", valid_b, data_b, ts_b);
        end
        tick();
        checks++;
        if ({done_b, busy_b, valid_b} !== 3'b100) begin
            errors++;
            $display("FAIL single_done: got done=%b busy=%b v=%b expected done=1 busy=0 v=0", done_b, busy_b, valid_b);
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (en_cnt_b !== 1 || hs_cnt_b !== 1 || done_b !== 1'b1) begin
            errors++;
            $display("FAIL single_counts: got en_pulses=%0d handshakes=%0d done=%b expected 1 1 1", en_cnt_b, hs_cnt_b, done_b);
        end
        start_b = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_held_start();
        test_backpressure();
        test_midrun_reset();
        test_single();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
